// File: rtl/bitwise_pkg.sv
// Shared opcode and FSM-state encodings for the slice-serial bitwise unit.
// No logic; no latency; no flow control.
// Imported by bitwise_slice and bitwise_slice_seq.
package bitwise_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'b00,
        OP_OR  = 2'b01,
        OP_XOR = 2'b10,
        OP_NOR = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/bitwise_slice.sv
// Combinational SLICE-bit AND/OR/XOR/NOR evaluator.
// Zero latency (pure combinational).
// No flow control; the sequencer decides when the output is captured.
module bitwise_slice
    import bitwise_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [1:0]       op,
    input  logic [SLICE-1:0] a_slice,
    input  logic [SLICE-1:0] b_slice,
    output logic [SLICE-1:0] s_slice
);

    always_comb begin
        s_slice = '0;
        case (op_e'(op))
            OP_AND: s_slice = a_slice & b_slice;
            OP_OR:  s_slice = a_slice | b_slice;
            OP_XOR: s_slice = a_slice ^ b_slice;
            OP_NOR: s_slice = ~(a_slice | b_slice);
        endcase
    end

endmodule

// File: rtl/bitwise_slice_seq.sv
// Slice-serial bitwise unit: latches operands, evaluates SLICE bits per clock into s.
// Latency: out_valid rises WIDTH/SLICE cycles after the accept edge.
// Backpressure: result and out_valid held until out_ready; in_ready only in IDLE. Optional zero flag: BITWISE_SEQ_ZERO_FLAG_EN.
module bitwise_slice_seq
    import bitwise_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             busy
`ifdef BITWISE_SEQ_ZERO_FLAG_EN
   ,output logic             zero
`endif
);

    localparam int NSL   = WIDTH / SLICE;
    localparam int CNT_W = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSL - 1);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    generate
        if (WIDTH % SLICE != 0) begin : g_bad_cfg
            $error("bitwise_slice_seq: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    logic [1:0]                   state;
    logic [CNT_W-1:0]             cnt;
    logic [1:0]                   op_q;
    logic [NSL-1:0][SLICE-1:0]    a_q;
    logic [NSL-1:0][SLICE-1:0]    b_q;
    logic [NSL-1:0][SLICE-1:0]    s_q;
    logic [SLICE-1:0]             s_slice;
`ifdef BITWISE_SEQ_ZERO_FLAG_EN
    logic                         zero_q;
`endif

    bitwise_slice #(.SLICE(SLICE)) u_slice (
        .op      (op_q),
        .a_slice (a_q[cnt]),
        .b_slice (b_q[cnt]),
        .s_slice (s_slice)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
`ifdef BITWISE_SEQ_ZERO_FLAG_EN
            zero_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        op_q  <= op;
                        s_q   <= '0;
                        cnt   <= '0;
                        state <= ST_RUN;
`ifdef BITWISE_SEQ_ZERO_FLAG_EN
                        zero_q <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    s_q[cnt] <= s_slice;
                    if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
`ifdef BITWISE_SEQ_ZERO_FLAG_EN
                        // Unwritten slices are still zero, so s_q plus this slice is the full result.
                        zero_q <= (s_q == '0) && (s_slice == '0);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_RUN) || (state == ST_DONE);
    assign s         = s_q;
`ifdef BITWISE_SEQ_ZERO_FLAG_EN
    assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_bitwise_slice_seq.sv
// Directed and randomized checks of bitwise_slice_seq against a whole-word reference model.
module tb_bitwise_slice_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, out_ready;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        in_ready, out_valid, busy;
    logic [31:0] s;

    logic        sw_valid, sw_ready;
    logic [31:0] sw_a, sw_b;
    logic        rdy32, ov32, busy32, rdy1, ov1, busy1;
    logic [31:0] s32, s1;
`ifdef BITWISE_SEQ_ZERO_FLAG_EN
    logic        zero, zero32, zero1;
`endif

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int acc_cyc[$];
    logic [31:0] res_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) acc_cyc.push_back(cyc);
            if (out_valid && out_ready) res_q.push_back(s);
        end
    end

    bitwise_slice_seq #(.WIDTH(32), .SLICE(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .busy(busy)
`ifdef BITWISE_SEQ_ZERO_FLAG_EN
       ,.zero(zero)
`endif
    );

    bitwise_slice_seq #(.WIDTH(32), .SLICE(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy32),
        .op(2'b01), .a(sw_a), .b(sw_b), .out_valid(ov32), .out_ready(sw_ready),
        .s(s32), .busy(busy32)
`ifdef BITWISE_SEQ_ZERO_FLAG_EN
       ,.zero(zero32)
`endif
    );

    bitwise_slice_seq #(.WIDTH(32), .SLICE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(rdy1),
        .op(2'b01), .a(sw_a), .b(sw_b), .out_valid(ov1), .out_ready(sw_ready),
        .s(s1), .busy(busy1)
`ifdef BITWISE_SEQ_ZERO_FLAG_EN
       ,.zero(zero1)
`endif
    );

    function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Called #1 after a rising edge; returns with out_valid high (or the bound expired).
    task automatic send(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
        int n;
        op = o; a = x; b = y; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        int lat, n, lat32, lat1, diff;
        logic [1:0]  o1, o2, ro;
        logic [31:0] x1, y1, x2, y2, rx, ry, held, r32, r1, got0, got1;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 2'b00; a = '0; b = '0;
        sw_valid = 1'b0; sw_ready = 1'b1; sw_a = '0; sw_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_s", s, 0);
`ifdef BITWISE_SEQ_ZERO_FLAG_EN
        check("rst_zero", zero, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // OR with consumer always ready
        send(2'b01, 32'hF0F0_0000, 32'h0F0F_00FF, lat);
        check("or_latency", lat, 4);
        check("or_s", s, ref_op(2'b01, 32'hF0F0_0000, 32'h0F0F_00FF));
        check("or_busy_done", busy, 1);
`ifdef BITWISE_SEQ_ZERO_FLAG_EN
        check("or_zero", zero, 0);
`endif
        @(posedge clk); #1;
        check("or_drained", out_valid, 0);
        check("or_ready_again", in_ready, 1);

        send(2'b11, 32'h0, 32'h0, lat);
        check("nor_s", s, 32'hFFFF_FFFF);
        @(posedge clk); #1;

        send(2'b00, 32'hAAAA_AAAA, 32'h5555_5555, lat);
        check("and_s", s, 32'h0000_0000);
`ifdef BITWISE_SEQ_ZERO_FLAG_EN
        check("and_zero", zero, 1);
`endif
        @(posedge clk); #1;

        // XOR held under backpressure while in_valid pulses are ignored
        out_ready = 1'b0;
        send(2'b10, 32'h1234_5678, 32'hFFFF_FFFF, lat);
        check("xor_s", s, 32'hEDCB_A987);
        held = s;
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            a = $urandom; b = $urandom; op = 2'($urandom);
            @(posedge clk); #1;
            check("bp_s_stable", s, 32'hEDCB_A987);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_drained", out_valid, 0);
        check("bp_no_queued_req", busy, 0);

        // Reset two cycles into a run
        op = 2'b01; a = $urandom; b = $urandom; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy_before_rst", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_s", s, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("mid_no_partial_valid", out_valid, 0);
        send(2'b00, 32'hFFFF_0000, 32'h0F0F_0F0F, lat);
        check("post_rst_latency", lat, 4);
        check("post_rst_and_s", s, 32'h0F0F_0000);
        @(posedge clk); #1;

        // Back-to-back requests with operands changing after each accept
        acc_cyc.delete(); res_q.delete();
        o1 = 2'($urandom); x1 = $urandom; y1 = $urandom;
        o2 = 2'($urandom); x2 = $urandom; y2 = $urandom;
        op = o1; a = x1; b = y1; in_valid = 1'b1;
        n = 0;
        while (acc_cyc.size() < 1 && n < 50) begin @(posedge clk); #1; n++; end
        op = o2; a = x2; b = y2;
        while (acc_cyc.size() < 2 && n < 100) begin @(posedge clk); #1; n++; end
        in_valid = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        while (res_q.size() < 2 && n < 150) begin @(posedge clk); #1; n++; end
        diff = (acc_cyc.size() >= 2) ? acc_cyc[1] - acc_cyc[0] : -1;
        got0 = (res_q.size() >= 1) ? res_q[0] : 32'hxxxx_xxxx;
        got1 = (res_q.size() >= 2) ? res_q[1] : 32'hxxxx_xxxx;
        check("b2b_accept_spacing", diff, 6);
        check("b2b_result0", got0, ref_op(o1, x1, y1));
        check("b2b_result1", got1, ref_op(o2, x2, y2));
        @(posedge clk); #1;

        // Randomized ops with random consumer stalls
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom); rx = $urandom; ry = $urandom;
            if (i == 0) begin rx = 32'h0; ry = 32'h0; ro = 2'b00; end
            out_ready = 1'($urandom_range(0, 1));
            send(ro, rx, ry, lat);
            check("rand_latency", lat, 4);
            check("rand_s", s, ref_op(ro, rx, ry));
`ifdef BITWISE_SEQ_ZERO_FLAG_EN
            check("rand_zero", zero, 32'(ref_op(ro, rx, ry) == 32'h0));
`endif
            if (!out_ready) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
                check("rand_held", s, ref_op(ro, rx, ry));
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
            check("rand_drained", out_valid, 0);
        end

        // SLICE sweep: full-width and single-bit slices, OR of random operands
        for (int i = 0; i < 2; i++) begin
            sw_a = $urandom; sw_b = $urandom; sw_valid = 1'b1;
            @(posedge clk); #1;
            sw_valid = 1'b0;
            lat32 = 0; lat1 = 0; r32 = '0; r1 = '0;
            for (int c = 1; c <= 40; c++) begin
                @(posedge clk); #1;
                if (ov32 && lat32 == 0) begin lat32 = c; r32 = s32; end
                if (ov1 && lat1 == 0) begin lat1 = c; r1 = s1; end
            end
            check("sweep32_latency", lat32, 1);
            check("sweep1_latency", lat1, 32);
            check("sweep32_s", r32, sw_a | sw_b);
            check("sweep1_s", r1, sw_a | sw_b);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
